// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch-side push, issue-side pop and multiclock handshake of the decode queue.
interface decode_queue_if #(parameter int DEPTH = 4, parameter int PC_W = 32);
    logic                         in_valid;
    logic                         in_ready;
    logic [31:0]                  in_ir;
    logic [PC_W-1:0]              in_pc;
    logic                         flush;
    logic                         out_valid;
    logic                         out_ready;
    logic [31:0]                  out_ir;
    logic [PC_W-1:0]              out_pc;
    logic [4:0]                   out_rs1;
    logic [4:0]                   out_rs2;
    logic [4:0]                   out_rd;
    logic                         out_reg_we;
    logic                         out_is_multiclock;
    logic                         out_illegal;
    logic                         mc_done;
    logic                         mc_wait;
    logic [$clog2(DEPTH+1)-1:0]   count;
    modport master (
        output in_valid, in_ir, in_pc, flush, out_ready, mc_done,
        input  in_ready, out_valid, out_ir, out_pc, out_rs1, out_rs2, out_rd,
               out_reg_we, out_is_multiclock, out_illegal, mc_wait, count
    );
    modport slave (
        input  in_valid, in_ir, in_pc, flush, out_ready, mc_done,
        output in_ready, out_valid, out_ir, out_pc, out_rs1, out_rs2, out_rd,
               out_reg_we, out_is_multiclock, out_illegal, mc_wait, count
    );
endinterface

// File: rtl/decode_queue.sv
// decode_queue: circular instruction FIFO with combinational RV32IM field decode of the head
// and a stall state that holds issue while a multiclock (M-extension) operation completes.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input logic          clk,
    input logic          rst_n,
    decode_queue_if.slave q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    typedef enum logic {RUN, MC_WAIT} state_t;
    state_t          state, state_nxt;
    logic [31:0]     ir_mem [DEPTH];
    logic [PC_W-1:0] pc_mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   cnt;
    logic            push, pop;
    logic [31:0]     ir;
    logic [6:0]      op;
    logic            is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_imm, is_op;
    assign q.in_ready  = cnt < CW'(DEPTH);
    assign q.out_valid = (cnt != '0) && (state == RUN);
    assign q.mc_wait   = state == MC_WAIT;
    assign q.count     = cnt;
    assign push        = q.in_valid && q.in_ready && !q.flush;
    assign pop         = q.out_valid && q.out_ready;
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            state  <= RUN;
        end else begin
            cnt    <= q.flush ? '0 : cnt + CW'(push) - CW'(pop);
            wr_ptr <= q.flush ? '0 : wr_ptr + AW'(push);
            rd_ptr <= q.flush ? '0 : rd_ptr + AW'(pop);
            state  <= state_nxt;
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            ir_mem[wr_ptr] <= q.in_ir;
            pc_mem[wr_ptr] <= q.in_pc;
        end
    end
    // Entry pop wins over a coincident mc_done; flush never leaves MC_WAIT.
    always_comb begin
        state_nxt = (state == RUN && pop && q.out_is_multiclock) ? MC_WAIT :
                    (state == MC_WAIT && q.mc_done)              ? RUN     : state;
    end
    assign ir       = ir_mem[rd_ptr];
    assign op       = ir[6:0];
    assign is_lui   = op == 7'b0110111;
    assign is_auipc = op == 7'b0010111;
    assign is_jal   = op == 7'b1101111;
    assign is_jalr  = op == 7'b1100111;
    assign is_br    = op == 7'b1100011;
    assign is_ld    = op == 7'b0000011;
    assign is_st    = op == 7'b0100011;
    assign is_imm   = op == 7'b0010011;
    assign is_op    = op == 7'b0110011;
    assign q.out_ir            = ir;
    assign q.out_pc            = pc_mem[rd_ptr];
    assign q.out_rs1           = (is_lui || is_auipc || is_jal) ? 5'd0 : ir[19:15];
    assign q.out_rs2           = (is_op || is_br || is_st) ? ir[24:20] : 5'd0;
    assign q.out_rd            = (is_br || is_st) ? 5'd0 : ir[11:7];
    assign q.out_reg_we        = is_lui || is_auipc || is_ld || is_imm || is_op ||
                                 ((is_jal || is_jalr) && ir[11:7] != 5'd0);
    assign q.out_is_multiclock = is_op && ir[31:25] == 7'b0000001;
    assign q.out_illegal       = !(is_lui || is_auipc || is_jal || is_jalr || is_br ||
                                   is_ld || is_st || is_imm || is_op);
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed pushes with hand-decoded expectations queued to a scoreboard;
// a monitor compares every popped head against the oldest expectation.
module tb_decode_queue;
    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic        we, mc, ill;
    } exp_t;
    logic clk = 0;
    logic rst_n = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    decode_queue_if #(.DEPTH(4), .PC_W(32)) q();
    decode_queue #(.DEPTH(4), .PC_W(32)) dut (.clk(clk), .rst_n(rst_n), .q(q));
    always #5 clk = ~clk;
    function automatic exp_t mk(input logic [31:0] ir, pc, input logic [4:0] rs1, rs2, rd,
                                input logic we, mc, ill);
        mk.ir = ir; mk.pc = pc; mk.rs1 = rs1; mk.rs2 = rs2; mk.rd = rd;
        mk.we = we; mk.mc = mc; mk.ill = ill;
    endfunction
    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (rst_n && q.out_valid && q.out_ready) begin
            if (sb.size() == 0) chk("unexpected_pop", 96'(q.out_ir), 96'h0);
            else chk("pop_head", 96'({q.out_ir, q.out_pc, q.out_rs1, q.out_rs2, q.out_rd,
                                      q.out_reg_we, q.out_is_multiclock, q.out_illegal}),
                     96'(sb.pop_front()));
        end
    end
    // One cycle of offer; the word is expected only if the queue takes it.
    task automatic send(input exp_t e);
        q.in_valid = 1; q.in_ir = e.ir; q.in_pc = e.pc;
        @(negedge clk);
        if (q.in_ready && !q.flush) sb.push_back(e);
        @(posedge clk); #1;
        q.in_valid = 0;
    endtask
    task automatic drain();
        q.out_ready = 1;
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_done", 96'(sb.size()), 96'd0);
        q.out_ready = 0;
        chk("drain_count", 96'(q.count), 96'd0);
    endtask
    task automatic step(); @(posedge clk); #1; endtask
    initial begin
        q.in_valid = 0; q.in_ir = 0; q.in_pc = 0; q.flush = 0; q.out_ready = 0; q.mc_done = 0;
        #3;
        chk("rst_count", 96'(q.count), 96'd0);
        chk("rst_in_ready", 96'(q.in_ready), 96'd1);
        chk("rst_out_valid", 96'(q.out_valid), 96'd0);
        chk("rst_mc_wait", 96'(q.mc_wait), 96'd0);
        #9 rst_n = 1;
        step();
        // ADDI into an empty queue: visible only the cycle after the push
        q.in_valid = 1; q.in_ir = 32'h00308293; q.in_pc = 32'h100;
        #2 chk("no_bypass", 96'(q.out_valid), 96'd0);
        q.in_valid = 0;
        send(mk(32'h00308293, 32'h100, 1, 0, 5, 1, 0, 0));
        chk("addi_valid", 96'(q.out_valid), 96'd1);
        chk("addi_fields", 96'({q.out_pc, q.out_rs1, q.out_rs2, q.out_rd, q.out_reg_we}),
            96'({32'h100, 5'd1, 5'd0, 5'd5, 1'b1}));
        drain();
        // fill to DEPTH, fifth word refused
        send(mk(32'h123453B7, 32'h104, 0, 0, 7, 1, 0, 0));
        send(mk(32'h0000006F, 32'h108, 0, 0, 0, 0, 0, 0));
        send(mk(32'h002081B3, 32'h10C, 1, 2, 3, 1, 0, 0));
        send(mk(32'h00208063, 32'h110, 1, 2, 0, 0, 0, 0));
        chk("full_count", 96'(q.count), 96'd4);
        chk("full_in_ready", 96'(q.in_ready), 96'd0);
        send(mk(32'h00308293, 32'h114, 1, 0, 5, 1, 0, 0));
        chk("full_refuse", 96'(q.count), 96'd4);
        drain();
        // refills that cross the pointer wrap
        send(mk(32'h0020A023, 32'h200, 1, 2, 0, 0, 0, 0));
        send(mk(32'hFFFFFFFF, 32'h204, 31, 0, 31, 0, 0, 1));
        send(mk(32'h00308293, 32'h208, 1, 0, 5, 1, 0, 0));
        drain();
        send(mk(32'h000280E7, 32'h20C, 5, 0, 1, 1, 0, 0));
        send(mk(32'h00001517, 32'h210, 0, 0, 10, 1, 0, 0));
        drain();
        // MUL stalls issue while pushes continue
        q.out_ready = 1;
        send(mk(32'h022081B3, 32'h300, 1, 2, 3, 1, 1, 0));
        send(mk(32'h00308293, 32'h304, 1, 0, 5, 1, 0, 0));
        for (int i = 0; i < 10; i++) begin
            chk("mc_stall", 96'({q.mc_wait, q.out_valid}), 96'({1'b1, 1'b0}));
            if (i == 4) send(mk(32'h123453B7, 32'h308, 0, 0, 7, 1, 0, 0));
            else step();
        end
        chk("mc_push_count", 96'(q.count), 96'd2);
        q.mc_done = 1; step(); q.mc_done = 0;
        chk("mc_resume", 96'({q.mc_wait, q.out_valid}), 96'({1'b0, 1'b1}));
        drain();
        // mc_done coincident with the entry pop is ignored
        q.out_ready = 1;
        send(mk(32'h022081B3, 32'h400, 1, 2, 3, 1, 1, 0));
        q.mc_done = 1; step(); q.mc_done = 0;
        chk("mc_entry_done_ignored", 96'(q.mc_wait), 96'd1);
        q.mc_done = 1; step(); q.mc_done = 0;
        chk("mc_exit", 96'(q.mc_wait), 96'd0);
        q.out_ready = 0;
        // flush with a simultaneous offer
        send(mk(32'h00308293, 32'h500, 1, 0, 5, 1, 0, 0));
        send(mk(32'h0020A023, 32'h504, 1, 2, 0, 0, 0, 0));
        send(mk(32'h00208063, 32'h508, 1, 2, 0, 0, 0, 0));
        chk("pre_flush_count", 96'(q.count), 96'd3);
        q.flush = 1;
        send(mk(32'hFFFFFFFF, 32'h50C, 31, 0, 31, 0, 0, 1));
        q.flush = 0;
        sb.delete();
        chk("flush_count", 96'(q.count), 96'd0);
        chk("flush_out_valid", 96'(q.out_valid), 96'd0);
        send(mk(32'h00001517, 32'h510, 0, 0, 10, 1, 0, 0));
        drain();
        // asynchronous reset during MC_WAIT with two entries queued
        q.out_ready = 1;
        send(mk(32'h022081B3, 32'h600, 1, 2, 3, 1, 1, 0));
        send(mk(32'h00308293, 32'h604, 1, 0, 5, 1, 0, 0));
        send(mk(32'h123453B7, 32'h608, 0, 0, 7, 1, 0, 0));
        chk("pre_rst_state", 96'({q.mc_wait, q.count}), 96'({1'b1, 3'd2}));
        q.out_ready = 0;
        #2 rst_n = 0;
        #1;
        chk("async_rst", 96'({q.count, q.mc_wait, q.in_ready, q.out_valid}),
            96'({3'd0, 1'b0, 1'b1, 1'b0}));
        sb.delete();
        #2 rst_n = 1;
        step();
        chk("post_rst", 96'({q.count, q.out_valid}), 96'({3'd0, 1'b0}));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
